// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial W-bit subtractor computing a - b, LSB first,
// one bit per clock. A single full-subtractor slice, a borrow flop, two operand
// shift registers, a result shift register and a bit counter.
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN (registered signed-overflow
// flag). Without it the ovf port is tied to 0 and no extra flops exist.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         ovf
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Full-subtractor borrow-out.
    function automatic logic fs_bout(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    state_t         state_r, state_s;
    logic [W-1:0]   a_sh_r, a_sh_s;
    logic [W-1:0]   b_sh_r, b_sh_s;
    logic [W-1:0]   res_r, res_s;
    logic           bor_r, bor_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic           busy_r, busy_s;
    logic           done_r, done_s;
    logic [W-1:0]   diff_r, diff_s;
    logic           borrow_r, borrow_s;
    logic           bit_diff_s;
    logic           bit_bout_s;
    logic           last_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic           a_sign_r, a_sign_s;
    logic           b_sign_r, b_sign_s;
    logic           ovf_r, ovf_s;
`endif

    // The slice always looks at the current LSBs and the stored borrow.
    assign bit_diff_s = fs_diff(a_sh_r[0], b_sh_r[0], bor_r);
    assign bit_bout_s = fs_bout(a_sh_r[0], b_sh_r[0], bor_r);
    assign last_s     = (cnt_r == CW'(W - 1));

    // Next-state and next-datapath computation; every register holds by default.
    always_comb begin
        state_s  = state_r;
        a_sh_s   = a_sh_r;
        b_sh_s   = b_sh_r;
        res_s    = res_r;
        bor_s    = bor_r;
        cnt_s    = cnt_r;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        diff_s   = diff_r;
        borrow_s = borrow_r;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        a_sign_s = a_sign_r;
        b_sign_s = b_sign_r;
        ovf_s    = ovf_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                // DONE accepts start exactly like IDLE so back-to-back runs have no bubble.
                if (start) begin
                    state_s = RUN;
                    a_sh_s  = a;
                    b_sh_s  = b;
                    bor_s   = 1'b0;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    a_sign_s = a[W-1];
                    b_sign_s = b[W-1];
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                a_sh_s = {1'b0, a_sh_r[W-1:1]};
                b_sh_s = {1'b0, b_sh_r[W-1:1]};
                res_s  = {bit_diff_s, res_r[W-1:1]};
                bor_s  = bit_bout_s;
                cnt_s  = cnt_r + CW'(1);
                if (last_s) begin
                    state_s  = DONE;
                    done_s   = 1'b1;
                    busy_s   = 1'b0;
                    diff_s   = {bit_diff_s, res_r[W-1:1]};
                    borrow_s = bit_bout_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // Overflow when operand signs differ and the result sign differs from a.
                    ovf_s = (a_sign_r != b_sign_r) && (bit_diff_s != a_sign_r);
`endif
                end else begin
                    state_s = RUN;
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_r    <= '0;
            bor_r    <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_sign_r <= 1'b0;
            b_sign_r <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            a_sh_r   <= a_sh_s;
            b_sh_r   <= b_sh_s;
            res_r    <= res_s;
            bor_r    <= bor_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            diff_r   <= diff_s;
            borrow_r <= borrow_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_sign_r <= a_sign_s;
            b_sign_r <= b_sign_s;
            ovf_r    <= ovf_s;
`endif
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign diff   = diff_r;
    assign borrow = borrow_r;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf    = ovf_r;
`else
    assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: table of W=8 vectors, hand-written
// sequences for ignored start / back-to-back / async reset, and an exhaustive
// back-to-back sweep on a W=2 instance.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       rst, start, start2;
    logic [7:0] a, b, diff;
    logic       busy, done, borrow, ovf;
    logic [1:0] a2, b2, diff2;
    logic       busy2, done2, borrow2, ovf2;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
    );

    serial_subtractor #(.W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2), .ovf(ovf2)
    );

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] ed;
        logic       eb;
        logic       eo;   // expected ovf when the overflow feature is built in
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // From the negedge after the start edge, step until done (bounded), checking busy.
    task automatic wait_done(output int c);
        c = 0;
        while (done !== 1'b1 && c < 40) begin
            chk("busy_run", 32'(busy), 32'd1);
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ed,
                          input logic eb, input logic eo, input string nm);
        int c;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb;
        chk({nm, "_done_early"}, 32'(done), 32'd0);
        wait_done(c);
        chk({nm, "_latency"}, c, 32'd8);
        chk({nm, "_busy_done"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_borrow"}, 32'(borrow), 32'(eb));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo & OVF_EN));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_diff_hold"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        int c;
        int seen;
        logic [3:0] iv;
        logic [1:0] ea, eb2, ed2;
        logic       eo2;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
        vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        a = 8'h00; b = 8'h00; a2 = 2'd0; b2 = 2'd0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].eo, $sformatf("vec%0d", i));
        end

        // start during RUN is ignored; start held through DONE gives back-to-back run.
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0; c = 0;
        @(negedge clk); c++;
        @(negedge clk); c++;
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk); c++;
        start = 1'b0; a = 8'h33; b = 8'h77;
        chk("ign_diff_stable", 32'(diff), 32'h4B);
        while (done !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("ign_latency", c, 32'd8);
        chk("ign_diff", 32'(diff), 32'h0F);
        chk("ign_borrow", 32'(borrow), 32'd0);
        a = 8'h20; b = 8'h30; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_diff_stable", 32'(diff), 32'h0F);
        wait_done(c);
        chk("b2b_latency", c, 32'd8);
        chk("b2b_diff", 32'(diff), 32'hF0);
        chk("b2b_borrow", 32'(borrow), 32'd1);
        chk("b2b_ovf", 32'(ovf), 32'd0);

        // Asynchronous reset between edges aborts the run.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_borrow", 32'(borrow), 32'd0);
        #1 rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("arst_no_done", seen, 32'd0);
        run_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, "post_rst");

        // Exhaustive W=2 sweep, start held high so runs are back-to-back.
        @(negedge clk);
        a2 = 2'd0; b2 = 2'd0; start2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            iv = 4'(i);
            ea = iv[3:2];
            eb2 = iv[1:0];
            @(posedge clk);
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (done2 !== 1'b1 && c < 10);
            ed2 = ea - eb2;
            eo2 = (ea[1] != eb2[1]) && (ed2[1] != ea[1]);
            // one negedge right after the capture edge, then W=2 processing edges
            chk($sformatf("w2_lat_%0d", i), c, 32'd3);
            chk($sformatf("w2_diff_%0d", i), 32'(diff2), 32'(ed2));
            chk($sformatf("w2_borrow_%0d", i), 32'(borrow2), 32'(ea < eb2));
            chk($sformatf("w2_ovf_%0d", i), 32'(ovf2), 32'(eo2 & OVF_EN));
            if (i < 15) begin
                iv = 4'(i + 1);
                a2 = iv[3:2];
                b2 = iv[1:0];
            end else begin
                start2 = 1'b0;
            end
        end
        @(negedge clk);
        chk("w2_idle", 32'(busy2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
